// File: rtl/wb_arbiter_rr_if.sv
// Write-back bus between the execution-unit producers and the arbiter.
// The producer side (master) presents per-channel results and sees the grant;
// the arbiter (slave) returns the grant and drives the registered write port.
interface wb_arbiter_rr_if #(
  parameter int N_CH  = 3,
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 32
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]      res_v;
  logic [N_CH*XLEN-1:0] res;
  logic [N_CH*RD_W-1:0] rd_i;
  logic [N_CH-1:0]      exc_i;
  logic [N_CH-1:0]      ok_o;
  logic [XLEN-1:0]      result;
  logic [RD_W-1:0]      rd;
  logic                 result_v;
  logic                 exc_o;
  logic [CH_W-1:0]      exc_ch;
  logic [CNT_W-1:0]     retired;

  modport master (
    output res_v, res, rd_i, exc_i,
    input  ok_o, result, rd, result_v, exc_o, exc_ch, retired
  );

  modport slave (
    input  res_v, res, rd_i, exc_i,
    output ok_o, result, rd, result_v, exc_o, exc_ch, retired
  );
endinterface

// File: rtl/wb_arbiter_rr.sv
// Round-robin write-back arbiter: merges N_CH producer channels into one
// registered register-file write port, with exception priority, exception
// channel reporting and a retired-instruction counter.
module wb_arbiter_rr #(
  parameter int N_CH  = 3,
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 32
) (
  input logic             clk,
  input logic             rst,
  wb_arbiter_rr_if.slave  bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CH_W-1:0] ptr;

  logic            exc_found;
  logic [CH_W-1:0] exc_idx;
  logic            hi_found;
  logic [CH_W-1:0] hi_idx;
  logic            lo_found;
  logic [CH_W-1:0] lo_idx;

  logic            gnt_any;
  logic            gnt_exc;
  logic [CH_W-1:0] gnt_idx;
  logic [N_CH-1:0] gnt_oh;
  logic [XLEN-1:0] sel_res;
  logic [RD_W-1:0] sel_rd;

  // Pick the granted channel: lowest-index exception first, otherwise the
  // first valid channel at or above ptr, otherwise the lowest valid (wrap).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and infers a latch.
    exc_found = 1'b0;
    exc_idx   = '0;
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_found  = 1'b0;
    lo_idx    = '0;
    // Descending scan: the last hit written is the lowest index.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus.res_v[i]) begin
        lo_found = 1'b1;
        lo_idx   = CH_W'(i);
        if (CH_W'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = CH_W'(i);
        end
        if (bus.exc_i[i]) begin
          exc_found = 1'b1;
          exc_idx   = CH_W'(i);
        end
      end
    end
    gnt_exc = exc_found && !rst;
    gnt_any = lo_found && !rst;
    if (exc_found)     gnt_idx = exc_idx;
    else if (hi_found) gnt_idx = hi_idx;
    else               gnt_idx = lo_idx;
  end

  // Decode the grant to one-hot and select the granted channel's payload.
  always_comb begin
    gnt_oh  = '0;
    sel_res = '0;
    sel_rd  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == CH_W'(i)) begin
        gnt_oh[i] = gnt_any;
        sel_res   = bus.res[i*XLEN +: XLEN];
        sel_rd    = bus.rd_i[i*RD_W +: RD_W];
      end
    end
  end

  assign bus.ok_o = gnt_oh;

  // Advance the pointer past each grant and register the write-back beat.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      ptr          <= '0;
      bus.result   <= '0;
      bus.rd       <= '0;
      bus.result_v <= 1'b0;
      bus.exc_o    <= 1'b0;
      bus.exc_ch   <= '0;
      bus.retired  <= '0;
    end else begin
      bus.result_v <= 1'b0;
      bus.exc_o    <= 1'b0;
      if (gnt_any) begin
        ptr <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
        if (gnt_exc) begin
          bus.exc_o  <= 1'b1;
          bus.exc_ch <= gnt_idx;
        end else begin
          // A write to x0 is dropped at the port but still retires.
          bus.result   <= sel_res;
          bus.rd       <= sel_rd;
          bus.result_v <= (sel_rd != '0);
          bus.retired  <= bus.retired + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/wb_arbiter_rr.md
Name: wb_arbiter_rr

Overview:
- Parametrised successor to the fixed three-source write-back stage.
- Merges results from N_CH execution units (alu, mem, csr, and future units) into the single register-file write port.
- Arbitration is fair round-robin; at most one result retires per cycle; output is registered.
- Also reports exceptions with the source channel index, and counts retired instructions.

Parameters:
N_CH, 3, number of producer channels (2..8)
XLEN, 32, result width
RD_W, 5, destination register index width
CNT_W, 32, width of the retired-instruction counter
CH_W, $clog2(N_CH) (min 1), channel index width (derived, localparam)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
res_v  in  N_CH  per-channel result valid
res  in  N_CH*XLEN  per-channel result, channel i at [i*XLEN +: XLEN]
rd_i  in  N_CH*RD_W  per-channel destination index, channel i at [i*RD_W +: RD_W]
exc_i  in  N_CH  per-channel exception flag, qualified by res_v[i]
ok_o  out  N_CH  per-channel accept (grant), combinational
result  out  XLEN  registered write data
rd  out  RD_W  registered write index
result_v  out  1  registered register-file write enable
exc_o  out  1  registered one-cycle exception pulse
exc_ch  out  CH_W  channel that raised exc_o
retired  out  CNT_W  count of accepted non-exception beats

Behaviour:
- Transfer on channel i when res_v[i] && ok_o[i] in the same cycle. A producer holds res/rd_i/exc_i stable while res_v is high and unaccepted.
- Grant logic is combinational:
  - Search starts at pointer ptr (CH_W bits) and goes upward, wrapping N_CH-1 -> 0.
  - The first channel with res_v high is granted. ok_o is one-hot or zero.
  - ok_o never depends on the output registers.
- Exception priority: if any res_v[i] && exc_i[i] is high, the lowest-index such channel is granted, overriding round-robin.
- ptr update:
  - After any grant to channel g: ptr <= (g == N_CH-1) ? 0 : g+1.
  - No grant: ptr holds.
  - An exception grant also advances ptr.
- Output registers, one-cycle latency from the transfer edge:
  - Non-exception grant: result <= res[g], rd <= rd_i[g], result_v <= (rd_i[g] != 0). Writes to x0 are dropped, but the beat still retires.
  - Exception grant: result_v <= 0, exc_o <= 1, exc_ch <= g; result and rd hold.
  - No grant: result_v <= 0, exc_o <= 0; result, rd and exc_ch hold.
- retired increments by 1 on each non-exception transfer, including rd == 0. It wraps 2^CNT_W-1 -> 0 and does not saturate.
- No backpressure from the register file; the output is accepted every cycle. Sustained throughput is one beat per cycle.
- Reset values (sync rst high, applied at clock edge): result = 0, rd = 0, result_v = 0, exc_o = 0, exc_ch = 0, retired = 0, ptr = 0.
- ok_o is forced to 0 while rst is high. No beats are accepted during reset; producers must re-present them after reset.
- Boundary cases:
  - N_CH = 2 uses CH_W = 1.
  - All channels valid every cycle: each channel granted exactly once per N_CH cycles.
  - A single valid channel is granted every cycle regardless of ptr.
  - Exceptions on two channels in the same cycle: the lower index wins, and the other is granted on a later cycle.

Test Plan:
- Reset: hold rst 2 cycles with all res_v = 1 -> ok_o = 000 throughout; after release result_v = 0, retired = 0, ptr = 0; first grant goes to ch0.
- Round-robin fairness (N_CH = 3): all res_v = 1 for 6 cycles, rd_i = 1,2,3 -> grant order 0,1,2,0,1,2; rd output sequence 1,2,3,1,2,3 one cycle later; retired = 6.
- x0 drop: ch1 only, rd_i = 0, res = 0xDEADBEEF -> ok_o = 010, result_v = 0 next cycle, retired increments by 1.
- Exception override: ptr = 1, res_v = 111, exc_i = 101 -> ch0 granted; next cycle exc_o = 1, exc_ch = 0, result_v = 0, retired unchanged; following cycle ch2 (exc) granted, exc_ch = 2.
- Counter wrap: CNT_W = 4, 17 non-exception beats -> retired reads 15 then 0 then 1.
- Mid-stream reset: rst asserted while ch2 pending with ptr = 2 -> next cycle all outputs at reset values, ptr = 0; after release ch2 is re-granted with the same data.
